// File: rtl/param_dec_pkg.sv
// Shared encodings for the parameterised decoder/sequencer: FSM states and mode constants.
// No logic lives here, so it has no latency and no flow control.
package param_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/param_dec_dwell_cnt.sv
// Loadable down-counter that times one select slot; tc is high while the count is zero.
// load takes effect on the next edge; tc is combinational from the count register.
// No backpressure: the counter stops at zero, so it never wraps.
module param_dec_dwell_cnt #(
    parameter int dwell_width = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [dwell_width-1:0] load_val,
    input  logic                   dec,
    output logic                   tc
);

    logic [dwell_width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - dwell_width'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/param_dec_seq.sv
// One-hot select generator: decodes an accepted code x or scans all lines, each slot dwell+1 cycles.
// y is registered, so it changes 1 cycle after acceptance or scan start.
// x_ready is high only in IDLE with decode mode; requests are ignored while busy.
module param_dec_seq
    import param_dec_pkg::*;
#(
    parameter int input_width  = 2,
    parameter int output_width = 4,
    parameter int dwell_width  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [input_width-1:0]  x,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic                    mode,
    input  logic                    en,
    input  logic [dwell_width-1:0]  dwell,
    output logic [output_width-1:0] y,
    output logic                    busy,
    output logic                    err
);

    localparam logic [input_width:0]    OW_LIM   = (input_width + 1)'(output_width);
    localparam logic [input_width-1:0]  POS_LAST = input_width'(output_width - 1);
    localparam logic [output_width-1:0] ONE      = output_width'(1);

    state_t                  state_q, state_d;
    logic [input_width-1:0]  pos_q, pos_d;
    logic [output_width-1:0] y_d;
    logic                    err_d;
    logic                    stop_q, stop_d;
    logic                    cnt_load, cnt_dec, cnt_tc;

    assign x_ready = (state_q == IDLE) && (mode == MODE_DECODE);
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        y_d      = y;
        err_d    = 1'b0;
        stop_d   = stop_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                y_d    = '0;
                stop_d = 1'b0;
                if (x_ready && x_valid) begin
                    if ({1'b0, x} < OW_LIM) begin
                        state_d  = HOLD;
                        y_d      = ONE << x;
                        cnt_load = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if ((mode == MODE_SCAN) && en) begin
                    state_d  = SCAN;
                    pos_d    = '0;
                    y_d      = ONE;
                    cnt_load = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_tc) begin
                    state_d = IDLE;
                    y_d     = '0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SCAN: begin
                // en low at any point in a slot lets that slot finish, then stops
                stop_d = stop_q | ~en;
                if (cnt_tc) begin
                    if (stop_q || !en) begin
                        state_d = IDLE;
                        y_d     = '0;
                        stop_d  = 1'b0;
                    end else begin
                        pos_d    = (pos_q == POS_LAST) ? '0 : pos_q + input_width'(1);
                        y_d      = ONE << pos_d;
                        cnt_load = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            y       <= '0;
            err     <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            y       <= y_d;
            err     <= err_d;
            stop_q  <= stop_d;
        end
    end

    param_dec_dwell_cnt #(
        .dwell_width(dwell_width)
    ) u_dwell_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .load_val(dwell),
        .dec     (cnt_dec),
        .tc      (cnt_tc)
    );

endmodule

// File: tb/tb_param_dec_seq.sv
// Directed bench for param_dec_seq: default instance (2/4/8) and a narrow instance (2/3/3).
module tb_param_dec_seq;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0] xa, xb;
    logic       xva, xvb, moda, modb, ena, enb;
    logic [7:0] dwa;
    logic [2:0] dwb;
    logic [3:0] ya;
    logic [2:0] yb;
    logic       rdya, rdyb, busya, busyb, erra, errb;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] scan_exp [7];

    always #5 clk = ~clk;

    param_dec_seq #(.input_width(2), .output_width(4), .dwell_width(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .x(xa), .x_valid(xva), .x_ready(rdya),
        .mode(moda), .en(ena), .dwell(dwa), .y(ya), .busy(busya), .err(erra)
    );

    param_dec_seq #(.input_width(2), .output_width(3), .dwell_width(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .x(xb), .x_valid(xvb), .x_ready(rdyb),
        .mode(modb), .en(enb), .dwell(dwb), .y(yb), .busy(busyb), .err(errb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // y must never carry more than one set bit
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("onehot_a", 32'($onehot0(ya)), 32'd1);
            check("onehot_b", 32'($onehot0(yb)), 32'd1);
        end
    end

    initial begin
        scan_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        rst_n = 1'b0;
        xa = '0; xva = 1'b0; moda = 1'b0; ena = 1'b0; dwa = '0;
        xb = '0; xvb = 1'b0; modb = 1'b0; enb = 1'b0; dwb = '0;

        // reset state
        #12;
        check("rst_y", 32'(ya), 32'd0);
        check("rst_busy", 32'(busya), 32'd0);
        check("rst_err", 32'(erra), 32'd0);
        check("rst_rdy_decode", 32'(rdya), 32'd1);
        moda = 1'b1;
        #0.5;
        check("rst_rdy_scan", 32'(rdya), 32'd0);
        moda = 1'b0;

        // decode x=3, dwell=2, accepted on the first edge after release
        xa = 2'd3; xva = 1'b1; dwa = 8'd2;
        rst_n = 1'b1;
        tick();
        check("dec_y0", 32'(ya), 32'h8);
        check("dec_rdy_hold", 32'(rdya), 32'd0);
        check("dec_busy", 32'(busya), 32'd1);
        xva = 1'b0;
        tick();
        check("dec_y1", 32'(ya), 32'h8);
        tick();
        check("dec_y2", 32'(ya), 32'h8);
        check("dec_rdy_hold2", 32'(rdya), 32'd0);
        tick();
        check("dec_y_end", 32'(ya), 32'h0);
        check("dec_busy_end", 32'(busya), 32'd0);
        check("dec_rdy_end", 32'(rdya), 32'd1);

        // back-to-back requests with x_valid held
        dwa = 8'd0; xa = 2'd1; xva = 1'b1;
        tick();
        check("b2b_y1", 32'(ya), 32'h2);
        xa = 2'd2;
        tick();
        check("b2b_gap", 32'(ya), 32'h0);
        tick();
        check("b2b_y2", 32'(ya), 32'h4);
        xva = 1'b0;
        tick();
        check("b2b_end", 32'(ya), 32'h0);

        // scan with wrap, dwell=0, then drop en during the 0100 slot
        moda = 1'b1; ena = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("scan_seq", 32'(ya), 32'(scan_exp[i]));
        end
        ena = 1'b0;
        tick();
        check("scan_stop_y", 32'(ya), 32'h0);
        check("scan_stop_busy", 32'(busya), 32'd0);
        check("scan_idle_rdy", 32'(rdya), 32'd0);

        // asynchronous reset while y=0100
        ena = 1'b1;
        tick();
        check("rs_y1", 32'(ya), 32'h1);
        tick();
        check("rs_y2", 32'(ya), 32'h2);
        tick();
        check("rs_y4", 32'(ya), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async_y", 32'(ya), 32'h0);
        check("rs_async_busy", 32'(busya), 32'd0);
        moda = 1'b0; ena = 1'b0; xa = 2'd0; xva = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        check("rs_after_y", 32'(ya), 32'h1);
        xva = 1'b0;
        tick();
        check("rs_after_end", 32'(ya), 32'h0);

        // out-of-range code on the 3-line instance
        xb = 2'd3; xvb = 1'b1;
        tick();
        check("oor_err", 32'(errb), 32'd1);
        check("oor_y", 32'(yb), 32'd0);
        check("oor_busy", 32'(busyb), 32'd0);
        check("oor_rdy", 32'(rdyb), 32'd1);
        xvb = 1'b0;
        tick();
        check("oor_err_pulse", 32'(errb), 32'd0);

        // maximum dwell: 8-cycle slots
        modb = 1'b1; enb = 1'b1; dwb = 3'd7;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("maxd_slot0", 32'(yb), 32'h1);
        end
        tick();
        check("maxd_slot1_start", 32'(yb), 32'h2);
        enb = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("maxd_slot1", 32'(yb), 32'h2);
        end
        tick();
        check("maxd_stop_y", 32'(yb), 32'h0);
        check("maxd_stop_busy", 32'(busyb), 32'd0);

        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/param_dec_seq.md
PARAM_DEC_SEQ -- requirements
Module: param_dec_seq

Interface
REQ-001 The module SHALL expose the parameter input_width, default 2, meaning the width of the code input x.
REQ-002 The module SHALL expose the parameter output_width, default 4, meaning the number of one-hot select lines; legal range 2 <= output_width <= 2**input_width.
REQ-003 The module SHALL expose the parameter dwell_width, default 8, meaning the width of the dwell input.
REQ-004 Port clk: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port x: input, input_width bits, the code to decode in decode mode.
REQ-007 Port x_valid: input, 1 bit, x carries a request.
REQ-008 Port x_ready: output, 1 bit, the block accepts a request this cycle.
REQ-009 Port mode: input, 1 bit; 0 = decode, 1 = scan.
REQ-010 Port en: input, 1 bit, scan enable.
REQ-011 Port dwell: input, dwell_width bits; each active slot lasts dwell+1 cycles.
REQ-012 Port y: output, output_width bits, registered one-hot select, or all-zero.
REQ-013 Port busy: output, 1 bit, high in any state other than IDLE.
REQ-014 Port err: output, 1 bit, one-cycle pulse flagging an out-of-range code.

Function
REQ-015 The FSM SHALL have three states: IDLE, HOLD and SCAN.
REQ-016 In IDLE, y SHALL be 0, and x_ready SHALL equal (mode == 0).
REQ-017 A request is accepted when x_valid and x_ready are both high; dwell is sampled at acceptance into the dwell counter.
REQ-018 On accepting an in-range request (x < output_width), the FSM SHALL go to HOLD and y SHALL become 1 << x on the next cycle (1-cycle latency).
REQ-019 On accepting an out-of-range request (x >= output_width), y SHALL stay 0, err SHALL pulse high for exactly one cycle, and the FSM SHALL stay in IDLE.
REQ-020 In HOLD, x_ready SHALL be 0 and y SHALL hold for exactly dwell+1 cycles; the FSM then SHALL return to IDLE with y = 0.
REQ-021 A new request SHALL be accepted no earlier than the first IDLE cycle after HOLD, so consecutive selects are separated by at least one all-zero cycle.
REQ-022 In IDLE with mode == 1 and en == 1, the FSM SHALL go to SCAN and y SHALL become bit 0 on the next cycle.
REQ-023 In SCAN, y SHALL advance one bit position every dwell+1 cycles, and SHALL wrap from bit output_width-1 to bit 0.
REQ-024 In SCAN, dwell SHALL be re-sampled at each slot boundary.
REQ-025 If en is sampled low in SCAN, the current slot SHALL complete, and then the FSM SHALL go to IDLE with y = 0.
REQ-026 A change of mode while busy SHALL be ignored until the FSM is back in IDLE.
REQ-027 x and x_valid SHALL be ignored while busy.
REQ-028 y SHALL be either zero-hot or one-hot in every cycle; it SHALL never have more than one bit set.
REQ-029 dwell = 0 SHALL give single-cycle slots; the maximum dwell SHALL give 2**dwell_width cycles, with no counter overflow.

Reset
REQ-030 While rst_n is low, the FSM SHALL be in IDLE; y, err, busy and the dwell counter SHALL be 0; and x_ready SHALL equal (mode == 0).
REQ-031 Reset asserted mid-HOLD or mid-SCAN SHALL clear y asynchronously, within the same cycle.
REQ-032 After reset deasserts, the first acceptance SHALL be possible on the first rising edge.

Structure
REQ-033 A shared package param_dec_pkg SHALL hold the FSM state encoding (IDLE, HOLD, SCAN) and the mode constants MODE_DECODE and MODE_SCAN.
REQ-034 A single sub-module, param_dec_dwell_cnt, SHALL implement the loadable down-counter with a terminal-count output, parameterised by dwell_width.
REQ-035 The one-hot generation and the scan-position register SHALL live in the top module.

Verification
REQ-036 Decode, defaults: mode=0, dwell=2, x=3 with x_valid for one cycle -> y=4'b1000 for exactly 3 cycles starting 1 cycle after acceptance, then 0; x_ready low during HOLD.
REQ-037 Out of range: output_width=3, x=3 -> err pulses for 1 cycle, y stays 0, busy stays 0, x_ready stays high.
REQ-038 Scan with wrap: mode=1, en=1, dwell=0 -> y sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; drop en during the 0100 slot -> y=0 after that slot ends.
REQ-039 Back-to-back requests: x_valid held high with x=1 then x=2, dwell=0 -> y = 0010, 0000, 0100, never two bits set in any cycle.
REQ-040 Reset mid-SCAN: assert rst_n low while y=0100 -> y=0 immediately, with no clock edge; after release with mode=0, x=0 -> y=0001 one cycle after acceptance.
REQ-041 Maximum dwell: dwell_width=3, dwell=7 -> each slot lasts exactly 8 cycles.
